// File: rtl/branch_pkg.sv
// branch_pkg: shared opcodes and sequencer state encodings
package branch_pkg;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_FLUSH = 2'd2} state_t;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO with occupancy count and async-reset pointer
module ret_stack #(
  parameter int ADDR_W = 5,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);
  localparam int IW = $clog2(DEPTH);
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [IW-1:0] wr_idx, rd_idx;
  assign wr_idx = IW'(count);
  assign rd_idx = IW'(count - 1'b1);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (push && !full) count <= count + 1'b1;
    else if (pop && !empty) count <= count - 1'b1;
  // contents need no reset; only the pointer defines validity
  always_ff @(posedge clk)
    if (push && !full) mem[wr_idx] <= din;
endmodule

// File: rtl/branch_seq.sv
// branch_seq: JMP/CALL/RET sequencer driving the program counter load and fetch flush
module branch_seq
  import branch_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_cond,
  input  logic [ADDR_W-1:0] cmd_target,
  input  logic              flag_z,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_val,
  output logic              flush,
  output logic [CW-1:0]     sp,
  input  logic              err_clr,
  output logic              err_ovf,
  output logic              err_unf
);
  state_t state, state_nx;
  logic take, do_jmp, do_call, do_ret, ovf, unf, go, full, empty;
  logic [ADDR_W-1:0] top;
  assign take = cmd_valid && state == ST_IDLE && !(cmd_cond && !flag_z);
  assign do_jmp = take && cmd_op == OP_JMP;
  assign do_call = take && cmd_op == OP_CALL && !full;
  assign ovf = take && cmd_op == OP_CALL && full;
  assign do_ret = take && cmd_op == OP_RET && !empty;
  assign unf = take && cmd_op == OP_RET && empty;
  assign go = do_jmp || do_call || do_ret;
  ret_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CW(CW)) u_stack (
    .clk(clk), .rst(rst), .push(do_call), .pop(do_ret), .din(pc_cur + 1'b1),
    .dout(top), .full(full), .empty(empty), .count(sp)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == ST_LOAD ? ST_FLUSH : state == ST_FLUSH ? ST_IDLE : go ? ST_LOAD : ST_IDLE;
  always_comb begin
    cmd_ready = state == ST_IDLE;
    pc_load = state == ST_LOAD;
    flush = state == ST_FLUSH;
  end
  // a new error event in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_val <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (go) pc_val <= do_ret ? top : cmd_target;
      err_ovf <= ovf || (err_ovf && !err_clr);
      err_unf <= unf || (err_unf && !err_clr);
    end
endmodule
